// File: rtl/stream_mac_neuron.sv
// Streaming multiply-accumulate neuron: N_INPUTS (activation, weight) beats plus a bias,
// rescaled and saturated to OUT_W. Define STREAM_MAC_RELU_EN to clamp negative sums to zero.
module stream_mac_neuron #(
    parameter int DATA_W     = 8,
    parameter int WEIGHT_W   = 8,
    parameter int N_INPUTS   = 16,
    parameter int ACC_W      = DATA_W + WEIGHT_W + $clog2(N_INPUTS) + 1,
    parameter int OUT_W      = 16,
    parameter int FRAC_SHIFT = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [WEIGHT_W-1:0] in_weight,
    input  logic [ACC_W-1:0]    bias,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_W-1:0]    out_data,
    output logic                out_sat
);

    localparam int PROD_W = DATA_W + WEIGHT_W;
    localparam int CNT_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam int EXT_W  = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_INPUTS - 1);
    localparam logic signed [EXT_W-1:0] OUT_MAX =
        {{(EXT_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [EXT_W-1:0] OUT_MIN =
        {{(EXT_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_OUT
    } state_t;

    state_t                    state_q, state_d;
    logic        [CNT_W-1:0]   cnt_q, cnt_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic        [OUT_W-1:0]   out_data_q, out_data_d;
    logic                      out_sat_q, out_sat_d;

    logic                      beat;
    logic                      first_beat;
    logic                      last_beat;
    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   acc_base;
    logic signed [ACC_W-1:0]   acc_next;
    logic signed [ACC_W-1:0]   acc_shift;
    logic signed [EXT_W-1:0]   s_ext;
    logic        [OUT_W-1:0]   fin_data;
    logic                      fin_sat;

    // A pending result only blocks input while downstream is stalled, so the
    // output handshake and the next vector's first beat can share one cycle.
    assign in_ready  = (state_q != S_OUT) || out_ready;
    assign beat      = in_valid && in_ready;
    assign out_valid = (state_q == S_OUT);
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

    // Any beat outside ACCUM starts a new vector (from OUT it implies out_ready).
    assign first_beat = (state_q != S_ACCUM);
    assign last_beat  = (N_INPUTS == 1) || ((state_q == S_ACCUM) && (cnt_q == CNT_LAST));

    assign prod     = $signed(in_data) * $signed(in_weight);
    assign prod_ext = ACC_W'(prod);
    assign acc_base = first_beat ? $signed(bias) : acc_q;
    assign acc_next = acc_base + prod_ext;

    assign acc_shift = acc_next >>> FRAC_SHIFT;

    always_comb begin
        s_ext    = {{(EXT_W - ACC_W){acc_shift[ACC_W-1]}}, acc_shift};
`ifdef STREAM_MAC_RELU_EN
        if (s_ext[EXT_W-1]) begin
            s_ext = '0;
        end
`endif
        fin_data = s_ext[OUT_W-1:0];
        fin_sat  = 1'b0;
        if (s_ext > OUT_MAX) begin
            fin_data = OUT_MAX[OUT_W-1:0];
            fin_sat  = 1'b1;
        end else if (s_ext < OUT_MIN) begin
            fin_data = OUT_MIN[OUT_W-1:0];
            fin_sat  = 1'b1;
        end
    end

    // NOTE: every always_comb target gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;

        if ((state_q == S_OUT) && out_ready) begin
            state_d = S_IDLE;
        end

        if (beat) begin
            acc_d   = acc_next;
            cnt_d   = first_beat ? CNT_W'(1) : cnt_q + CNT_W'(1);
            state_d = S_ACCUM;
            if (last_beat) begin
                state_d    = S_OUT;
                cnt_d      = '0;
                out_data_d = fin_data;
                out_sat_d  = fin_sat;
            end
        end
    end

    // NOTE: the accumulator is reset with the rest of the state so an aborted
    // vector leaves no trace; it is a single register, not a memory array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
        end
    end

endmodule
